// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, stall encoding,
// load opcodes, the EX->MEM bus layout and an address-alignment helper.
package mem_stage_pkg;

    localparam int StallBus     = 6;
    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [2:0] MemOpNone = 3'b000;
    localparam logic [2:0] MemOpLB   = 3'b001;
    localparam logic [2:0] MemOpLBU  = 3'b010;
    localparam logic [2:0] MemOpLH   = 3'b011;
    localparam logic [2:0] MemOpLHU  = 3'b100;
    localparam logic [2:0] MemOpLW   = 3'b101;

    // Field order matches the packed EX->MEM bus, MSB first.
    typedef struct packed {
        logic [2:0]  mem_op;
        logic [31:0] ex_pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    // Halfword loads need addr[0]=0; word loads (including codes 110/111)
    // need addr[1:0]=0. Byte loads and non-loads are never misaligned.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr);
        logic mis;
        case (op)
            MemOpLH, MemOpLHU:            mis = addr[0];
            MemOpLW, 3'b110, 3'b111:      mis = (addr != 2'b00);
            default:                      mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle around the MEM stage: stall vector, EX->MEM bus, SRAM read data
// in; MEM->WB and MEM->ID buses out. Optional mem_adel under MEM_ALIGN_CHK_EN.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [StallBus-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;
`ifdef MEM_ALIGN_CHK_EN
    logic                    mem_adel;
`endif

    // Surrounding pipeline side.
    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
`ifdef MEM_ALIGN_CHK_EN
        , input mem_adel
`endif
    );

    // The MEM stage itself.
    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_bus
`ifdef MEM_ALIGN_CHK_EN
        , output mem_adel
`endif
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load lane extraction: picks byte/halfword/word from the SRAM word by the low
// address bits (little-endian) and sign- or zero-extends it to 32 bits.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rd,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection for byte and halfword views of the read word.
    always_comb begin
        byte_s = 8'h00;
        case (addr)
            2'b00:   byte_s = rd[7:0];
            2'b01:   byte_s = rd[15:8];
            2'b10:   byte_s = rd[23:16];
            2'b11:   byte_s = rd[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr[1]) begin
            half_s = rd[31:16];
        end else begin
            half_s = rd[15:0];
        end
    end

    // Extension by load type; the spare codes behave as LW.
    always_comb begin
        load_data = 32'h0000_0000;
        case (mem_op)
            MemOpLB:              load_data = {{24{byte_s[7]}}, byte_s};
            MemOpLBU:             load_data = {24'h00_0000, byte_s};
            MemOpLH:              load_data = {{16{half_s[15]}}, half_s};
            MemOpLHU:             load_data = {16'h0000, half_s};
            MemOpLW, 3'b110, 3'b111: load_data = rd;
            default:              load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus under stall control, keeps the
// SRAM read word of the resident instruction so a held load keeps its data,
// and forms the WB and ID forwarding buses.
// Optional feature macro: MEM_ALIGN_CHK_EN (misaligned-load detect, mem_adel).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave mem_if
);

    ex_to_mem_t  ex_r;
    logic        first_cyc_r;
    logic [31:0] rdata_buf_r;
    logic [31:0] rd_s;
    logic [31:0] load_data_s;
    logic [31:0] rf_wdata_s;
    logic        rf_we_s;
    logic        misaligned_s;
    logic        unused_s;

    assign unused_s = ex_r.data_ram_en;

    // Pipeline register and first-cycle flag: bubble, load or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r        <= '0;
            first_cyc_r <= 1'b0;
        end else if (mem_if.stall[3] == Stop && mem_if.stall[4] == NoStop) begin
            ex_r        <= '0;
            first_cyc_r <= 1'b1;
        end else if (mem_if.stall[3] == NoStop) begin
            ex_r        <= mem_if.ex_to_mem_bus;
            first_cyc_r <= 1'b1;
        end else begin
            first_cyc_r <= 1'b0;
        end
    end

    // Capture the SRAM word at the end of the instruction's first MEM cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_buf_r <= 32'h0000_0000;
        end else if (first_cyc_r) begin
            rdata_buf_r <= mem_if.data_sram_rdata;
        end else begin
            rdata_buf_r <= rdata_buf_r;
        end
    end

    assign rd_s = first_cyc_r ? mem_if.data_sram_rdata : rdata_buf_r;

    mem_stage_load_ext u_load_ext (
        .mem_op    (ex_r.mem_op),
        .addr      (ex_r.ex_result[1:0]),
        .rd        (rd_s),
        .load_data (load_data_s)
    );

    // Write-back value and enable; stores and (optionally) misaligned loads
    // never write the register file from MEM.
    always_comb begin
        rf_wdata_s   = ex_r.ex_result;
        rf_we_s      = ex_r.rf_we;
        misaligned_s = 1'b0;
        if (ex_r.sel_rf_res) begin
            rf_wdata_s = load_data_s;
        end else begin
            rf_wdata_s = ex_r.ex_result;
        end
`ifdef MEM_ALIGN_CHK_EN
        misaligned_s = is_misaligned(ex_r.mem_op, ex_r.ex_result[1:0]);
`else
        misaligned_s = 1'b0;
`endif
        if (ex_r.data_ram_wen != 4'b0000 || misaligned_s) begin
            rf_we_s = 1'b0;
        end else begin
            rf_we_s = ex_r.rf_we;
        end
    end

    assign mem_if.mem_to_wb_bus = {ex_r.ex_pc, rf_we_s, ex_r.rf_waddr, rf_wdata_s};
    assign mem_if.mem_to_id_bus = {rf_we_s, ex_r.rf_waddr, rf_wdata_s};
`ifdef MEM_ALIGN_CHK_EN
    assign mem_if.mem_adel = misaligned_s;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: constant vector table, hand-written stall/bubble/reset
// sequences, then random traffic against a behavioural model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    mem_stage_if ifc ();

    mem_stage dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] STALL_RUN  = 6'b000000;
    localparam logic [5:0] STALL_BUB  = 6'b001000;
    localparam logic [5:0] STALL_HOLD = 6'b011000;

    // ---------------- behavioural model ----------------
    // The instruction resident in MEM, whether this is its first cycle there,
    // and the SRAM word it saw in that first cycle.
    ex_to_mem_t  m_instr;
    logic        m_fresh;
    logic [31:0] m_word;

    always @(posedge clk) begin
        if (rst) begin
            m_instr <= '0;
            m_fresh <= 1'b0;
            m_word  <= 32'h0;
        end else begin
            if (m_fresh) m_word <= ifc.data_sram_rdata;
            if (ifc.stall[3] == NoStop) begin
                m_instr <= ifc.ex_to_mem_bus;
                m_fresh <= 1'b1;
            end else if (ifc.stall[4] == NoStop) begin
                m_instr <= '0;
                m_fresh <= 1'b1;
            end else begin
                m_fresh <= 1'b0;
            end
        end
    end

    function automatic logic ref_misaligned(input logic [2:0] op, input logic [1:0] a);
        int unsigned ai;
        ai = a;
        if (op == 3'd3 || op == 3'd4) return (ai % 2) != 0;
        if (op >= 3'd5) return ai != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        int unsigned b;
        int unsigned h;
        int unsigned ai;
        ai = a;
        b = (rd >> (8 * ai)) & 32'hFF;
        h = (ai >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
        case (op)
            3'd1:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            3'd4:    return 32'(h);
            3'd0:    return 32'h0;
            default: return rd;
        endcase
    endfunction

    function automatic logic [69:0] ref_wb(input ex_to_mem_t m, input logic [31:0] rd);
        logic        we;
        logic [31:0] wd;
        we = m.rf_we && (m.data_ram_wen == 4'b0000);
`ifdef MEM_ALIGN_CHK_EN
        if (ref_misaligned(m.mem_op, m.ex_result[1:0])) we = 1'b0;
`endif
        wd = m.sel_rf_res ? ref_load(m.mem_op, m.ex_result[1:0], rd) : m.ex_result;
        return {m.ex_pc, we, m.rf_waddr, wd};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [69:0] e;
        e = ref_wb(m_instr, m_fresh ? ifc.data_sram_rdata : m_word);
        check({name, "_wb"}, ifc.mem_to_wb_bus, e);
        check({name, "_id"}, {32'h0, ifc.mem_to_id_bus}, {32'h0, e[37:0]});
`ifdef MEM_ALIGN_CHK_EN
        check({name, "_adel"}, {69'h0, ifc.mem_adel},
              {69'h0, ref_misaligned(m_instr.mem_op, m_instr.ex_result[1:0])});
`endif
    endtask

    function automatic ex_to_mem_t mk(input logic [2:0] op, input logic [31:0] pc,
                                      input logic [3:0] wen, input logic sel, input logic we,
                                      input logic [4:0] waddr, input logic [31:0] res);
        ex_to_mem_t m;
        m.mem_op = op;       m.ex_pc = pc;         m.data_ram_en = (op != 3'd0) || (wen != 4'd0);
        m.data_ram_wen = wen; m.sel_rf_res = sel;  m.rf_we = we;
        m.rf_waddr = waddr;  m.ex_result = res;
        return m;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] res;
        logic [3:0]  wen;
        logic        sel;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] rdata;
        logic        exp_we;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        n_total = 0;
        n_pass  = 0;
        vecs[0] = '{"alu",   3'd0, 32'h1234_5678, 4'h0, 1'b0, 1'b1, 5'd5,  32'hAAAA_5555, 1'b1, 32'h1234_5678};
        vecs[1] = '{"lb",    3'd1, 32'h1000_0002, 4'h0, 1'b1, 1'b1, 5'd7,  32'h0080_FF11, 1'b1, 32'hFFFF_FF80};
        vecs[2] = '{"lbu",   3'd2, 32'h1000_0002, 4'h0, 1'b1, 1'b1, 5'd7,  32'h0080_FF11, 1'b1, 32'h0000_0080};
        vecs[3] = '{"lhu",   3'd4, 32'h2000_0002, 4'h0, 1'b1, 1'b1, 5'd8,  32'h8001_0000, 1'b1, 32'h0000_8001};
        vecs[4] = '{"lh",    3'd3, 32'h2000_0002, 4'h0, 1'b1, 1'b1, 5'd8,  32'h8001_0000, 1'b1, 32'hFFFF_8001};
        vecs[5] = '{"lw",    3'd5, 32'h3000_0000, 4'h0, 1'b1, 1'b1, 5'd9,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{"lw111", 3'd7, 32'h3000_0004, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0123_4567, 1'b1, 32'h0123_4567};
        vecs[7] = '{"lb_b1", 3'd1, 32'h1000_0001, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0080_FF11, 1'b1, 32'hFFFF_FFFF};
        vecs[8] = '{"store", 3'd0, 32'h0000_0040, 4'hF, 1'b0, 1'b1, 5'd12, 32'h5555_5555, 1'b0, 32'h0000_0040};
        vecs[9] = '{"lbu_b3",3'd2, 32'h1000_0003, 4'h0, 1'b1, 1'b1, 5'd13, 32'h9A00_0000, 1'b1, 32'h0000_009A};

        // Reset state.
        rst = 1'b1;
        ifc.stall = STALL_RUN;
        ifc.ex_to_mem_bus = mk(3'd5, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b1, 5'd31, 32'h0);
        ifc.data_sram_rdata = 32'hFFFF_FFFF;
        next();
        next();
        @(negedge clk);
        check("reset_wb", ifc.mem_to_wb_bus, 70'h0);
        check("reset_id", {32'h0, ifc.mem_to_id_bus}, 70'h0);
        check_model("reset");
        next();
        rst = 1'b0;
        ifc.ex_to_mem_bus = '0;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 10; i++) begin
            ifc.stall = STALL_RUN;
            ifc.ex_to_mem_bus = mk(vecs[i].op, 32'h0040_0000 + 32'(i * 4), vecs[i].wen,
                                   vecs[i].sel, vecs[i].we, vecs[i].waddr, vecs[i].res);
            ifc.data_sram_rdata = $urandom;
            next();
            ifc.data_sram_rdata = vecs[i].rdata;
            ifc.ex_to_mem_bus = '0;
            @(negedge clk);
            check({vecs[i].name, "_wdata"}, {38'h0, ifc.mem_to_wb_bus[31:0]}, {38'h0, vecs[i].exp_wdata});
            check({vecs[i].name, "_we"}, {69'h0, ifc.mem_to_wb_bus[37]}, {69'h0, vecs[i].exp_we});
            check({vecs[i].name, "_waddr"}, {65'h0, ifc.mem_to_wb_bus[36:32]}, {65'h0, vecs[i].waddr});
            check({vecs[i].name, "_pc"}, {38'h0, ifc.mem_to_wb_bus[69:38]}, {38'h0, 32'h0040_0000 + 32'(i * 4)});
            check({vecs[i].name, "_id"}, {32'h0, ifc.mem_to_id_bus}, {32'h0, ifc.mem_to_wb_bus[37:0]});
            check_model(vecs[i].name);
        end

        // Load held in MEM for 3 cycles while the SRAM word changes.
        ifc.stall = STALL_RUN;
        ifc.ex_to_mem_bus = mk(3'd5, 32'h0040_1000, 4'h0, 1'b1, 1'b1, 5'd9, 32'h1000_0000);
        next();
        for (int k = 0; k < 4; k++) begin
            ifc.stall = (k == 3) ? STALL_RUN : STALL_HOLD;
            ifc.data_sram_rdata = (k == 0) ? 32'hDEAD_BEEF : 32'h0;
            ifc.ex_to_mem_bus = mk(3'd0, 32'h1, 4'h0, 1'b0, 1'b1, 5'd1, 32'h7777_7777);
            @(negedge clk);
            check("held_wdata", {38'h0, ifc.mem_to_wb_bus[31:0]}, {38'h0, 32'hDEAD_BEEF});
            check("held_we", {69'h0, ifc.mem_to_wb_bus[37]}, 70'h1);
            check_model("held");
            next();
        end

        // Bubble while MEM runs.
        ifc.stall = STALL_RUN;
        ifc.ex_to_mem_bus = mk(3'd0, 32'h0040_2000, 4'h0, 1'b0, 1'b1, 5'd3, 32'h0000_0033);
        next();
        ifc.stall = STALL_BUB;
        @(negedge clk);
        check("pre_bubble_we", {69'h0, ifc.mem_to_wb_bus[37]}, 70'h1);
        next();
        ifc.stall = STALL_RUN;
        ifc.ex_to_mem_bus = '0;
        @(negedge clk);
        check("bubble_wb_we", {69'h0, ifc.mem_to_wb_bus[37]}, 70'h0);
        check("bubble_id_we", {69'h0, ifc.mem_to_id_bus[37]}, 70'h0);
        check_model("bubble");

        // Reset in the middle of a held load.
        ifc.ex_to_mem_bus = mk(3'd5, 32'h0040_3000, 4'h0, 1'b1, 1'b1, 5'd4, 32'h0000_0050);
        next();
        ifc.stall = STALL_HOLD;
        ifc.data_sram_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("pre_rst_wdata", {38'h0, ifc.mem_to_wb_bus[31:0]}, {38'h0, 32'hDEAD_BEEF});
        rst = 1'b1;
        next();
        rst = 1'b0;
        ifc.data_sram_rdata = 32'h1111_1111;
        @(negedge clk);
        check("rst_stall_wb", ifc.mem_to_wb_bus, 70'h0);
        check("rst_stall_id", {32'h0, ifc.mem_to_id_bus}, 70'h0);
        check_model("rst_stall");
        next();
        @(negedge clk);
        check("rst_stall2_wb", ifc.mem_to_wb_bus, 70'h0);

`ifdef MEM_ALIGN_CHK_EN
        // Misaligned word load.
        ifc.stall = STALL_RUN;
        ifc.ex_to_mem_bus = mk(3'd5, 32'h0040_4000, 4'h0, 1'b1, 1'b1, 5'd6, 32'h1000_0002);
        next();
        ifc.ex_to_mem_bus = '0;
        @(negedge clk);
        check("adel", {69'h0, ifc.mem_adel}, 70'h1);
        check("adel_we", {69'h0, ifc.mem_to_wb_bus[37]}, 70'h0);
        check("adel_id_we", {69'h0, ifc.mem_to_id_bus[37]}, 70'h0);
        next();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [2:0] op;
            logic [3:0] wen;
            int         sp;
            rst = ($urandom_range(0, 39) == 0);
            sp  = $urandom_range(0, 7);
            case (sp)
                0, 1, 2: ifc.stall = STALL_RUN;
                3:       ifc.stall = STALL_BUB;
                4, 5:    ifc.stall = STALL_HOLD;
                6:       ifc.stall = 6'b010000;
                default: ifc.stall = 6'($urandom);
            endcase
            op  = 3'($urandom_range(0, 7));
            wen = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (wen != 4'h0) op = 3'd0;
            ifc.ex_to_mem_bus = mk(op, $urandom, wen, op != 3'd0, 1'($urandom),
                                   5'($urandom), $urandom);
            ifc.data_sram_rdata = ($urandom_range(0, 3) == 0) ? 32'h0000_0080 : $urandom;
            @(negedge clk);
            check_model("rand");
            next();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
